// File: rtl/adc_capture_ctrl.sv
// Capture controller: drops sinc3 settling samples after arming, then streams
// ADC words into a linear buffer spread across NUM_BANKS SRAM macros.
module adc_capture_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int NUM_BANKS = 4,
  parameter int DISCARD   = 3,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int PTR_W    = ADDR_W + BANK_W,
  localparam int CNT_W    = PTR_W + 1,
  localparam int MASK_W   = DATA_W / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    adc_dat_i,
  input  logic                 adc_dvalid_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 circular_i,
  input  logic [PTR_W-1:0]     num_samples_i,
  output logic [NUM_BANKS-1:0] mem_wenb_o,
  output logic [ADDR_W-1:0]    mem_waddr_o,
  output logic [DATA_W-1:0]    mem_data_o,
  output logic [MASK_W-1:0]    wmask_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 done_pulse_o,
  output logic                 wrapped_o,
  output logic [CNT_W-1:0]     count_o,
  output logic [PTR_W-1:0]     wr_ptr_o
);

  localparam int DISC_W = (DISCARD > 1) ? $clog2(DISCARD + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISCARD,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  n_lat;
  logic              circ_lat;
  logic [DISC_W-1:0] disc_cnt;
  logic [CNT_W-1:0]  ptr_inc;
  logic              last;

  always_comb begin
    ptr_inc = {1'b0, wr_ptr_o} + CNT_W'(1);
    last    = (ptr_inc == n_lat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      n_lat        <= '0;
      circ_lat     <= 1'b0;
      disc_cnt     <= '0;
      mem_wenb_o   <= '1;
      mem_waddr_o  <= '0;
      mem_data_o   <= '0;
      wmask_o      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      done_pulse_o <= 1'b0;
      wrapped_o    <= 1'b0;
      count_o      <= '0;
      wr_ptr_o     <= '0;
    end else begin
      // Write strobe and IRQ pulse are single-cycle unless reasserted below.
      mem_wenb_o   <= '1;
      wmask_o      <= '0;
      done_pulse_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            n_lat     <= (num_samples_i == '0) ? CNT_W'(NUM_BANKS << ADDR_W)
                                               : {1'b0, num_samples_i};
            circ_lat  <= circular_i;
            count_o   <= '0;
            wr_ptr_o  <= '0;
            wrapped_o <= 1'b0;
            done_o    <= 1'b0;
            disc_cnt  <= '0;
            busy_o    <= 1'b1;
            state     <= (DISCARD == 0) ? S_CAPTURE : S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (abort_i) begin
            state        <= S_DONE;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            done_pulse_o <= 1'b1;
          end else if (adc_dvalid_i) begin
            if (disc_cnt == DISC_W'(DISCARD - 1)) state <= S_CAPTURE;
            else disc_cnt <= disc_cnt + DISC_W'(1);
          end
        end
        S_CAPTURE: begin
          if (abort_i) begin
            state        <= S_DONE;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            done_pulse_o <= 1'b1;
          end else if (adc_dvalid_i) begin
            mem_wenb_o  <= ~(NUM_BANKS'(1) << wr_ptr_o[PTR_W-1:ADDR_W]);
            mem_waddr_o <= wr_ptr_o[ADDR_W-1:0];
            mem_data_o  <= adc_dat_i;
            wmask_o     <= '1;
            if (count_o != n_lat) count_o <= count_o + CNT_W'(1);
            if (last && circ_lat) begin
              wr_ptr_o  <= '0;
              wrapped_o <= 1'b1;
            end else begin
              wr_ptr_o <= ptr_inc[PTR_W-1:0];
            end
            if (last && !circ_lat) begin
              state        <= S_DONE;
              busy_o       <= 1'b0;
              done_o       <= 1'b1;
              done_pulse_o <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: directed stimulus pushes expected
// SRAM writes; a negedge monitor pops and compares each observed write.
module tb_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adc_dat_i;
  logic        adc_dvalid_i;
  logic        start_i;
  logic        abort_i;
  logic        circular_i;
  logic [10:0] num_samples_i;
  logic [3:0]  mem_wenb_o;
  logic [8:0]  mem_waddr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  wmask_o;
  logic        busy_o;
  logic        done_o;
  logic        done_pulse_o;
  logic        wrapped_o;
  logic [11:0] count_o;
  logic [10:0] wr_ptr_o;

  adc_capture_ctrl #(
    .DATA_W(32), .ADDR_W(9), .NUM_BANKS(4), .DISCARD(3)
  ) dut (
    .clk(clk), .rst(rst), .adc_dat_i(adc_dat_i), .adc_dvalid_i(adc_dvalid_i),
    .start_i(start_i), .abort_i(abort_i), .circular_i(circular_i),
    .num_samples_i(num_samples_i), .mem_wenb_o(mem_wenb_o),
    .mem_waddr_o(mem_waddr_o), .mem_data_o(mem_data_o), .wmask_o(wmask_o),
    .busy_o(busy_o), .done_o(done_o), .done_pulse_o(done_pulse_o),
    .wrapped_o(wrapped_o), .count_o(count_o), .wr_ptr_o(wr_ptr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  bank;
    logic [8:0]  addr;
    logic [31:0] data;
    logic        dp;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  dp_total = 0;
  int  dp_mark;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input int bank, input int addr, input logic [31:0] d, input logic dp);
    wr_t e;
    e.bank = bank[1:0];
    e.addr = addr[8:0];
    e.data = d;
    e.dp   = dp;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with write activity must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    logic [3:0] exp_wenb;
    if (done_pulse_o) dp_total++;
    if (mem_wenb_o != 4'hF || wmask_o != 4'h0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write wenb=%b addr=%0d data=%h required=no_write",
                 mem_wenb_o, mem_waddr_o, mem_data_o);
      end else begin
        e = exp_q.pop_front();
        exp_wenb = ~(4'b0001 << e.bank);
        chk("write", {14'd0, mem_wenb_o, mem_waddr_o, mem_data_o, wmask_o, done_pulse_o},
                     {14'd0, exp_wenb, e.addr, e.data, 4'hF, e.dp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [31:0] d, input int gap);
    adc_dat_i = d;
    adc_dvalid_i = 1'b1;
    tick();
    adc_dvalid_i = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_start(input logic [10:0] n, input logic circ);
    num_samples_i = n;
    circular_i = circ;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic discard3();
    for (int i = 0; i < 3; i++) sample(32'hDD00_0000 + i, 0);
  endtask

  initial begin
    rst = 1'b1;
    adc_dat_i = '0;
    adc_dvalid_i = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    circular_i = 1'b0;
    num_samples_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_mem", {15'd0, mem_wenb_o, mem_waddr_o, mem_data_o, wmask_o},
                     {15'd0, 4'hF, 9'd0, 32'd0, 4'h0});
    chk("reset_status", {33'd0, busy_o, done_o, done_pulse_o, wrapped_o, count_o, wr_ptr_o}, 64'd0);

    // 1: single-shot N=5, sparse strobes, first three dropped
    dp_mark = dp_total;
    do_start(11'd5, 1'b0);
    chk("t1_busy", busy_o, 1);
    for (int i = 0; i < 9; i++) begin
      if (i >= 3 && i <= 7) push(0, i - 3, 32'hA0 + i, i == 7);
      sample(32'hA0 + i, 3);
    end
    tick();
    chk("t1_count", count_o, 5);
    chk("t1_wr_ptr", wr_ptr_o, 5);
    chk("t1_done_busy", {done_o, busy_o}, 2'b10);
    chk("t1_dp_cycles", dp_total - dp_mark, 1);

    // 2: N=0 means 2048, back-to-back strobes walk all four banks
    dp_mark = dp_total;
    do_start(11'd0, 1'b0);
    for (int i = 0; i < 2052; i++) begin
      adc_dat_i = (i < 3) ? 32'hDEAD_0000 + i : 32'hB000_0000 + (i - 3);
      adc_dvalid_i = 1'b1;
      if (i >= 3 && i < 2051) push((i - 3) >> 9, (i - 3) & 511, 32'hB000_0000 + (i - 3), i == 2050);
      tick();
    end
    adc_dvalid_i = 1'b0;
    repeat (2) tick();
    chk("t2_count", count_o, 2048);
    chk("t2_wr_ptr", wr_ptr_o, 0);
    chk("t2_done", done_o, 1);
    chk("t2_dp_cycles", dp_total - dp_mark, 1);

    // 3: circular N=4, ten captured samples then abort
    dp_mark = dp_total;
    do_start(11'd4, 1'b1);
    chk("t3_done_cleared", done_o, 0);
    discard3();
    for (int i = 0; i < 10; i++) begin
      push(0, i % 4, 32'hC0 + i, 1'b0);
      sample(32'hC0 + i, 1);
      if (i == 2) chk("t3_not_wrapped", wrapped_o, 0);
      if (i == 4) chk("t3_wrapped", wrapped_o, 1);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    repeat (3) tick();
    chk("t3_count", count_o, 4);
    chk("t3_wr_ptr", wr_ptr_o, 2);
    chk("t3_status", {done_o, busy_o, wrapped_o}, 3'b101);
    chk("t3_dp_cycles", dp_total - dp_mark, 1);

    // 4: abort coincident with third captured strobe
    dp_mark = dp_total;
    do_start(11'd8, 1'b0);
    chk("t4_wrapped_cleared", wrapped_o, 0);
    discard3();
    push(0, 0, 32'hD0, 1'b0);
    sample(32'hD0, 0);
    push(0, 1, 32'hD1, 1'b0);
    sample(32'hD1, 0);
    abort_i = 1'b1;
    sample(32'hD2, 0);
    abort_i = 1'b0;
    repeat (3) tick();
    sample(32'hD3, 3);
    chk("t4_count", count_o, 2);
    chk("t4_done", {done_o, busy_o}, 2'b10);
    chk("t4_dp_cycles", dp_total - dp_mark, 1);

    // 5: reset the cycle after a captured strobe, then restart
    do_start(11'd8, 1'b0);
    discard3();
    push(0, 0, 32'hE0, 1'b0);
    sample(32'hE0, 0);
    push(0, 1, 32'hE1, 1'b0);
    sample(32'hE1, 0);
    rst = 1'b1;
    adc_dat_i = 32'hE2;
    adc_dvalid_i = 1'b1;
    tick();
    adc_dvalid_i = 1'b0;
    chk("t5_rst_mem", {15'd0, mem_wenb_o, mem_waddr_o, mem_data_o, wmask_o},
                      {15'd0, 4'hF, 9'd0, 32'd0, 4'h0});
    chk("t5_rst_status", {33'd0, busy_o, done_o, done_pulse_o, wrapped_o, count_o, wr_ptr_o}, 64'd0);
    rst = 1'b0;
    repeat (2) tick();
    do_start(11'd2, 1'b0);
    discard3();
    push(0, 0, 32'hE8, 1'b0);
    sample(32'hE8, 1);
    push(0, 1, 32'hE9, 1'b1);
    sample(32'hE9, 2);
    chk("t5_restart", {count_o, wr_ptr_o, done_o}, {12'd2, 11'd2, 1'b1});

    // 6: start ignored mid-capture; start+abort together ends capture
    do_start(11'd6, 1'b0);
    discard3();
    push(0, 0, 32'hF0, 1'b0);
    sample(32'hF0, 0);
    push(0, 1, 32'hF1, 1'b0);
    sample(32'hF1, 0);
    do_start(11'd1, 1'b1);
    chk("t6_ignored", {count_o, wr_ptr_o, busy_o, done_o}, {12'd2, 11'd2, 1'b1, 1'b0});
    push(0, 2, 32'hF2, 1'b0);
    sample(32'hF2, 0);
    push(0, 3, 32'hF3, 1'b0);
    sample(32'hF3, 1);
    chk("t6_continue", {count_o, wr_ptr_o, wrapped_o}, {12'd4, 11'd4, 1'b0});
    dp_mark = dp_total;
    abort_i = 1'b1;
    do_start(11'd3, 1'b0);
    abort_i = 1'b0;
    chk("t6_abort_wins", {done_o, busy_o, count_o}, {1'b1, 1'b0, 12'd4});
    repeat (2) tick();
    chk("t6_dp_cycles", dp_total - dp_mark, 1);
    abort_i = 1'b1;
    do_start(11'd3, 1'b0);
    abort_i = 1'b0;
    chk("t6_start_wins", {done_o, busy_o, count_o}, {1'b0, 1'b1, 12'd0});
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
